// File: rtl/hbm_phy_responder.sv
// HBM PHY-side channel model: READ/WRITE/REFRESH commands against a word store, periodic auto-refresh, address checking.
// Latency: first read beat RD_LAT cycles after READ acceptance, then BURST_LEN consecutive beats; error pulse the cycle after acceptance.
// Backpressure: phy_ready is low outside IDLE or while a refresh is pending; write beats may stall indefinitely via phy_wr_valid.
module hbm_phy_responder #(
  parameter int DATA_W       = 512,
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 256,
  parameter int BURST_LEN    = 4,
  parameter int RD_LAT       = 4,
  parameter int REF_INTERVAL = 1024,
  parameter int REF_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phy_cmd_valid,
  input  logic [1:0]        phy_cmd,
  input  logic [ADDR_W-1:0] phy_addr,
  input  logic [DATA_W-1:0] phy_wr_data,
  input  logic              phy_wr_valid,
  output logic              phy_ready,
  output logic [DATA_W-1:0] phy_rd_data,
  output logic              phy_rd_valid,
  output logic              phy_error,
  output logic [7:0]        err_count
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW   = $clog2(BURST_LEN) + 1;
  localparam int CMAX = (RD_LAT > REF_CYCLES) ? RD_LAT : REF_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RW   = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] MAX_BASE   = ADDR_W'(DEPTH - BURST_LEN);

  localparam logic [1:0] CMD_NOP     = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_REFRESH = 2'b11;

  typedef enum logic [2:0] {
    IDLE, WRITE_BURST, READ_LAT, READ_BURST, REFRESH, ERROR
  } state_t;

  state_t          state;
  logic [AW-1:0]   base;
  logic [BW-1:0]   beat;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   ref_cnt;
  logic            ref_pending;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          cmd_accept;
  logic          addr_bad;
  logic          ref_wrap;
  logic          mem_we;
  logic [AW-1:0] mem_idx;

  // Ready is forced low while reset is held so nothing is accepted before the FSM settles.
  assign phy_ready  = (state == IDLE) && !ref_pending && !reset;
  assign cmd_accept = phy_cmd_valid && phy_ready && (phy_cmd != CMD_NOP);
  // Full-width compare so high address bits can never alias into the store.
  assign addr_bad   = ((phy_addr & ALIGN_MASK) != '0) || (phy_addr > MAX_BASE);
  assign ref_wrap   = (ref_cnt == RW'(REF_INTERVAL - 1));
  assign mem_we     = (state == WRITE_BURST) && phy_wr_valid && !reset;
  assign mem_idx    = base + AW'(beat);

  // Free-running refresh interval timer, independent of FSM state.
  always_ff @(posedge clk) begin
    if (reset) ref_cnt <= '0;
    else if (ref_wrap) ref_cnt <= '0;
    else ref_cnt <= ref_cnt + RW'(1);
  end

  // Backing store; not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= phy_wr_data;
  end

  // Command FSM with registered read/error outputs and refresh bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      base         <= '0;
      beat         <= '0;
      cnt          <= '0;
      ref_pending  <= 1'b0;
      phy_rd_valid <= 1'b0;
      phy_rd_data  <= '0;
      phy_error    <= 1'b0;
      err_count    <= '0;
    end else begin
      // A wrap while already pending merges; a consuming refresh below overrides it.
      if (ref_wrap) ref_pending <= 1'b1;
      phy_rd_valid <= 1'b0;
      phy_rd_data  <= '0;
      phy_error    <= 1'b0;
      case (state)
        IDLE: begin
          if (ref_pending) begin
            state       <= REFRESH;
            cnt         <= '0;
            ref_pending <= 1'b0;
          end else if (cmd_accept) begin
            if (phy_cmd == CMD_REFRESH) begin
              state       <= REFRESH;
              cnt         <= '0;
              ref_pending <= 1'b0;
            end else if (addr_bad) begin
              state     <= ERROR;
              phy_error <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else begin
              base  <= phy_addr[AW-1:0];
              beat  <= '0;
              cnt   <= '0;
              state <= (phy_cmd == CMD_WRITE) ? WRITE_BURST : READ_LAT;
            end
          end
        end
        WRITE_BURST: begin
          if (phy_wr_valid) begin
            if (beat == BW'(BURST_LEN - 1)) state <= IDLE;
            else beat <= beat + BW'(1);
          end
        end
        READ_LAT: begin
          // The first beat is loaded on the edge leaving READ_LAT so it appears RD_LAT cycles after acceptance.
          if (cnt == CW'(RD_LAT - 1)) begin
            state        <= READ_BURST;
            phy_rd_valid <= 1'b1;
            phy_rd_data  <= mem[base];
            beat         <= BW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        READ_BURST: begin
          // Remains here while the last beat is on the bus so ready rises only afterwards.
          if (beat == BW'(BURST_LEN)) begin
            state <= IDLE;
          end else begin
            phy_rd_valid <= 1'b1;
            phy_rd_data  <= mem[mem_idx];
            beat         <= beat + BW'(1);
          end
        end
        REFRESH: begin
          if (cnt == CW'(REF_CYCLES - 1)) state <= IDLE;
          else cnt <= cnt + CW'(1);
        end
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hbm_phy_responder.sv
// Randomized scoreboard bench for hbm_phy_responder: driver pushes expected beats/errors, negedge monitor pops and compares.
// Reference: array store plus cycle stamps derived from the latency and refresh rules.
// Driver waits on phy_ready for handshakes; all waits are bounded.
module tb_hbm_phy_responder;
  localparam int DATA_W = 512, ADDR_W = 32, DEPTH = 256, BURST_LEN = 4;
  localparam int RD_LAT = 4, REF_INTERVAL = 1024, REF_CYCLES = 8;
  localparam logic [1:0] RD = 2'b01, WR = 2'b10, RF = 2'b11;

  logic clk, reset, phy_cmd_valid, phy_wr_valid;
  logic [1:0] phy_cmd;
  logic [ADDR_W-1:0] phy_addr;
  logic [DATA_W-1:0] phy_wr_data, phy_rd_data;
  logic phy_ready, phy_rd_valid, phy_error;
  logic [7:0] err_count;

  hbm_phy_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN),
    .RD_LAT(RD_LAT), .REF_INTERVAL(REF_INTERVAL), .REF_CYCLES(REF_CYCLES)) dut (
    .clk(clk), .reset(reset), .phy_cmd_valid(phy_cmd_valid), .phy_cmd(phy_cmd), .phy_addr(phy_addr),
    .phy_wr_data(phy_wr_data), .phy_wr_valid(phy_wr_valid), .phy_ready(phy_ready),
    .phy_rd_data(phy_rd_data), .phy_rd_valid(phy_rd_valid), .phy_error(phy_error), .err_count(err_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int cyc; logic [DATA_W-1:0] dat; } exp_t;
  exp_t rd_q[$];
  int   err_q[$];
  exp_t me;
  int   mc;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit   written [DEPTH];
  logic [DATA_W-1:0] wdat [BURST_LEN];
  int   exp_err = 0;
  int   checks = 0, errors = 0;
  int   cyc = 0, rcyc = 0;
  bit   mon_en = 1'b0;

  // Absolute cycle index and cycles since reset release (refresh timer reference).
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rcyc <= reset ? 0 : rcyc + 1;
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic flag(input string name, input int info);
    checks++;
    errors++;
    $display("FAIL %s cycle=%0d actual=%0d required=none", name, cyc, info);
  endtask

  // Monitor: compare every presented beat/error against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        me = rd_q.pop_front();
        flag("rd_beat_missing", me.cyc);
      end
      while (err_q.size() > 0 && err_q[0] < cyc) begin
        mc = err_q.pop_front();
        flag("error_missing", mc);
      end
      if (phy_rd_valid) begin
        if (rd_q.size() == 0) flag("rd_unexpected", 1);
        else begin
          me = rd_q.pop_front();
          chk("rd_cycle", cyc, me.cyc);
          chk("rd_data", phy_rd_data, me.dat);
        end
      end else begin
        chk("rd_data_idle_zero", phy_rd_data, '0);
      end
      if (phy_error) begin
        if (err_q.size() == 0) flag("error_unexpected", 1);
        else begin
          mc = err_q.pop_front();
          chk("error_cycle", cyc, mc);
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    int n = 0;
    while (cyc < t && n < 1000) begin tick(); n++; end
  endtask

  task automatic wait_rcyc(input int t);
    int n = 0;
    while (rcyc < t && n < 4000) begin tick(); n++; end
    if (rcyc != t) flag("sync_lost", rcyc);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (phy_ready !== 1'b1 && n < 200) begin tick(); n++; end
    if (phy_ready !== 1'b1) flag("ready_timeout", n);
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [ADDR_W-1:0] a, output int acc);
    wait_ready();
    phy_cmd_valid = 1'b1; phy_cmd = c; phy_addr = a;
    tick();
    acc = cyc;
    phy_cmd_valid = 1'b0; phy_cmd = 2'b00;
  endtask

  task automatic push_beats(input int acc, input int a);
    exp_t e;
    for (int i = 0; i < BURST_LEN; i++) begin
      e.cyc = acc + RD_LAT + i;
      e.dat = ref_mem[a + i];
      rd_q.push_back(e);
    end
  endtask

  task automatic do_read(input int a, input bit chk_end);
    int acc;
    send_cmd(RD, ADDR_W'(a), acc);
    push_beats(acc, a);
    wait_until(acc + RD_LAT + BURST_LEN - 1);
    chk("rd_ready_busy", phy_ready, 0);
    tick();
    if (chk_end) chk("rd_ready_after", phy_ready, 1);
  endtask

  task automatic do_write(input int a, input logic [15:0] pat, input bit chk_end);
    int acc, b = 0, k = 0;
    send_cmd(WR, ADDR_W'(a), acc);
    while (b < BURST_LEN && k < 200) begin
      phy_wr_valid = pat[k % 16];
      phy_wr_data  = pat[k % 16] ? wdat[b] : rnd_word();
      tick();
      if (pat[k % 16]) begin
        ref_mem[a + b] = wdat[b];
        written[a + b] = 1'b1;
        b++;
      end
      k++;
      if (b < BURST_LEN) chk("wr_busy", phy_ready, 0);
    end
    phy_wr_valid = 1'b0;
    if (chk_end) chk("wr_ready_after", phy_ready, 1);
  endtask

  task automatic do_bad(input logic [ADDR_W-1:0] a, input bit chk_rdy);
    int acc;
    send_cmd(($urandom_range(0, 1) == 0) ? RD : WR, a, acc);
    err_q.push_back(acc);
    exp_err++;
    tick();
    chk("err_count", err_count, (exp_err > 255) ? 255 : exp_err);
    if (chk_rdy) chk("err_ready_after", phy_ready, 1);
  endtask

  task automatic do_refresh_cmd();
    int acc, ra;
    send_cmd(RF, '0, acc);
    ra = rcyc;
    for (int k = 0; k < REF_CYCLES; k++) begin chk("refcmd_busy", phy_ready, 0); tick(); end
    if ((ra % REF_INTERVAL) != 0 && (ra % REF_INTERVAL) + REF_CYCLES < REF_INTERVAL)
      chk("refcmd_ready_after", phy_ready, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < BURST_LEN; i++) wdat[i] = rnd_word();
  endtask

  initial begin
    int acc, a, b, r;
    reset = 1'b1; phy_cmd_valid = 1'b0; phy_cmd = 2'b00; phy_addr = '0;
    phy_wr_data = '0; phy_wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", phy_ready, 0);
    chk("rst_rd_valid", phy_rd_valid, 0);
    chk("rst_rd_data", phy_rd_data, '0);
    chk("rst_error", phy_error, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
    chk("ready_after_reset", phy_ready, 1);

    // Basic write/read at 8 with known beats.
    for (int i = 0; i < BURST_LEN; i++) wdat[i] = {16{32'hA0A0_0000 + i}};
    do_write(8, 16'hFFFF, 1'b1);
    do_read(8, 1'b1);
    // Gapped write 1,0,0,1,1,0,1 at 16.
    fill_random();
    do_write(16, 16'h0059, 1'b1);
    do_read(16, 1'b1);
    // Highest legal base, read issued in the first IDLE cycle after the write.
    fill_random();
    do_write(DEPTH - BURST_LEN, 16'hFFFF, 1'b1);
    do_read(DEPTH - BURST_LEN, 1'b1);
    // Address errors: unaligned, out of range, far out of range.
    do_bad(32'd6, 1'b1);
    do_bad(32'd256, 1'b1);
    chk("err_count_two", err_count, 2);
    do_bad(32'hFFFF_FFFC, 1'b1);
    do_refresh_cmd();

    // Command held across the first auto-refresh: refresh wins, READ follows.
    wait_rcyc(REF_INTERVAL - 1);
    chk("pre_wrap_ready", phy_ready, 1);
    tick();
    phy_cmd_valid = 1'b1; phy_cmd = RD; phy_addr = 32'd8;
    for (int k = 0; k < REF_CYCLES + 1; k++) begin chk("wrap_ready_low", phy_ready, 0); tick(); end
    chk("wrap_ready_high", phy_ready, 1);
    acc = cyc + 1;
    push_beats(acc, 8);
    tick();
    phy_cmd_valid = 1'b0; phy_cmd = 2'b00;
    wait_until(acc + RD_LAT + BURST_LEN);
    chk("wrap_read_done_ready", phy_ready, 1);

    // READ two cycles before the second wrap: burst intact, then refresh.
    wait_rcyc(2 * REF_INTERVAL - 3);
    chk("pre_burst_ready", phy_ready, 1);
    phy_cmd_valid = 1'b1; phy_cmd = RD; phy_addr = 32'd16;
    tick();
    acc = cyc;
    phy_cmd_valid = 1'b0; phy_cmd = 2'b00;
    push_beats(acc, 16);
    for (int k = 0; k < RD_LAT + BURST_LEN + 1 + REF_CYCLES; k++) begin
      chk("burst_ref_ready_low", phy_ready, 0);
      tick();
    end
    chk("burst_ref_ready_high", phy_ready, 1);

    // Write stalled across two wraps yields a single refresh afterwards.
    fill_random();
    send_cmd(WR, 32'd32, acc);
    phy_wr_valid = 1'b1; phy_wr_data = wdat[0];
    tick();
    phy_wr_valid = 1'b0;
    ref_mem[32] = wdat[0];
    wait_rcyc(4 * REF_INTERVAL + 4);
    chk("stall_busy", phy_ready, 0);
    for (b = 1; b < BURST_LEN; b++) begin
      phy_wr_valid = 1'b1; phy_wr_data = wdat[b];
      tick();
      ref_mem[32 + b] = wdat[b];
    end
    phy_wr_valid = 1'b0;
    for (int i = 0; i < BURST_LEN; i++) written[32 + i] = 1'b1;
    for (int k = 0; k < REF_CYCLES + 1; k++) begin chk("stall_ref_low", phy_ready, 0); tick(); end
    for (int k = 0; k < 20; k++) begin chk("stall_single_ref", phy_ready, 1); tick(); end
    do_read(32, 1'b1);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, DEPTH / BURST_LEN - 1) * BURST_LEN;
      if (r <= 3 || (r <= 6 && !written[a])) begin
        fill_random();
        do_write(a, 16'($urandom()) | 16'h1, 1'b0);
      end else if (r <= 6) begin
        do_read(a, 1'b0);
      end else if (r <= 8) begin
        case ($urandom_range(0, 2))
          0: do_bad(ADDR_W'(a + $urandom_range(1, BURST_LEN - 1)), 1'b0);
          1: do_bad(ADDR_W'(DEPTH + $urandom_range(0, 255) * BURST_LEN), 1'b0);
          default: do_bad($urandom() | 32'h8000_0000, 1'b0);
        endcase
      end else begin
        do_refresh_cmd();
      end
    end

    // Error counter saturation.
    for (int n = 0; n < 260; n++) do_bad(32'd6, 1'b0);
    chk("err_count_sat", err_count, 255);

    // Reset in the middle of a read burst.
    send_cmd(RD, 32'd8, acc);
    push_beats(acc, 8);
    wait_until(acc + RD_LAT + 1);
    reset = 1'b1;
    while (rd_q.size() > 0 && rd_q[rd_q.size() - 1].cyc > cyc) rd_q.pop_back();
    exp_err = 0;
    tick();
    chk("midrst_rd_valid", phy_rd_valid, 0);
    chk("midrst_rd_data", phy_rd_data, '0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_ready", phy_ready, 0);
    reset = 1'b0;
    tick();
    chk("midrst_ready_after", phy_ready, 1);
    do_read(8, 1'b1);
    do_read(32, 1'b1);

    wait_until(cyc + 20);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
